// File: rtl/keyframe_fader_if.sv
// Bundles the keyframe write port, commit controls, driver read port and
// fade status of keyframe_fader into one connection.
interface keyframe_fader_if #(
  parameter int c_addr_w = 10,
  parameter int c_bpc    = 12,
  parameter int c_time_w = 10
);
  logic                i_wen;
  logic [c_addr_w-1:0] i_addr;
  logic [c_bpc-1:0]    i_data;
  logic [c_time_w-1:0] i_time;
  logic                i_start;
  logic [c_addr_w-1:0] i_rd_addr;
  logic [c_bpc-1:0]    o_rd_data;
  logic                o_busy;
  logic                o_done;

  modport master (
    output i_wen, i_addr, i_data, i_time, i_start, i_rd_addr,
    input  o_rd_data, o_busy, o_done
  );

  modport slave (
    input  i_wen, i_addr, i_data, i_time, i_start, i_rd_addr,
    output o_rd_data, o_busy, o_done
  );
endinterface

// File: rtl/keyframe_fader.sv
// Keyframe fader: collects per-channel targets, then on commit fades every
// channel linearly from its current value to its target over i_time steps.
// Channel stores are single-write-port arrays with registered reads.
module keyframe_fader #(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = 12,
  parameter int c_max_time  = 1024,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_time_w    = $clog2(c_max_time),
  parameter int c_tick_div  = 12000
) (
  input logic             i_clk,
  input logic             i_rst,
  keyframe_fader_if.slave bus
);
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SNAP, S_WAIT, S_DIV, S_SWEEP} state_t;

  localparam int c_idx_w  = c_addr_w + 1;
  localparam int c_pre_w  = $clog2(c_tick_div);
  localparam int c_cnt_w  = $clog2(c_time_w + 1);
  localparam int c_prod_w = c_bpc + c_time_w + 4;
  localparam logic [c_idx_w-1:0]         c_last     = c_idx_w'(c_channels - 1);
  localparam logic [c_idx_w-1:0]         c_end      = c_idx_w'(c_channels);
  localparam logic [c_pre_w-1:0]         c_pre_max  = c_pre_w'(c_tick_div - 1);
  localparam logic [c_cnt_w-1:0]         c_cnt_init = c_cnt_w'(c_time_w);
  localparam logic [c_time_w:0]          c_unity    = {1'b1, {c_time_w{1'b0}}};
  localparam logic signed [c_prod_w-1:0] c_max_p    = c_prod_w'((2 ** c_bpc) - 1);

  logic [c_bpc-1:0] t_mem [0:c_channels-1];
  logic [c_bpc-1:0] s_mem [0:c_channels-1];
  logic [c_bpc-1:0] c_mem [0:c_channels-1];

  state_t              state_reg, state_next;
  logic [c_idx_w-1:0]  idx_reg;
  logic [c_time_w-1:0] dur_reg, k_reg;
  logic [c_time_w:0]   f_reg, rem_reg, rem_sub;
  logic [c_cnt_w-1:0]  cnt_reg;
  logic [c_pre_w-1:0]  pre_reg;
  logic                pending_reg, tick, restart, rem_ge;
  logic                busy, done, wr_in_range, rd_in_range;

  // pipeline registers around the array reads
  logic [c_bpc-1:0]    t_rd_reg, s_rd_reg, c_snap_reg, c_rd_reg, byp_data_reg;
  logic                sw_valid_reg, snap_valid_reg, byp_hit_reg, rd_oob_reg;
  logic [c_addr_w-1:0] sw_addr_reg, snap_addr_reg;

  // write ports
  logic                t_we, s_we, c_we;
  logic [c_addr_w-1:0] t_waddr, s_waddr, c_waddr;
  logic [c_bpc-1:0]    t_wdata, s_wdata, c_wdata, snap_val, sweep_val;

  // blend arithmetic, all at one signed width
  logic signed [c_prod_w-1:0] t_ext, s_ext, f_ext, diff, prod, sum;

  wire [c_addr_w-1:0] idx_addr = idx_reg[c_addr_w-1:0];

  assign tick    = (pre_reg == c_pre_max);
  assign restart = bus.i_start && (state_reg != S_CLEAR);
  assign rem_ge  = (rem_reg >= {1'b0, dur_reg});
  assign rem_sub = rem_ge ? (rem_reg - {1'b0, dur_reg}) : rem_reg;

  // With a power-of-two channel count every address is valid.
  generate
    if (c_channels == (2 ** c_addr_w)) begin : g_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_partial
      assign wr_in_range = ({1'b0, bus.i_addr} < c_end);
      assign rd_in_range = ({1'b0, bus.i_rd_addr} < c_end);
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= S_CLEAR;
    else       state_reg <= state_next;
  end

  // Next-state logic; a commit outside CLEAR always (re)starts the snapshot.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CLEAR: if (idx_reg == c_last) state_next = S_IDLE;
      S_IDLE:  if (bus.i_start) state_next = S_SNAP;
      S_SNAP:  if (bus.i_start) state_next = S_SNAP;
               else if (idx_reg == c_last) state_next = (dur_reg == '0) ? S_SWEEP : S_WAIT;
      S_WAIT:  if (bus.i_start) state_next = S_SNAP;
               else if (tick || pending_reg) state_next = S_DIV;
      S_DIV:   if (bus.i_start) state_next = S_SNAP;
               else if (cnt_reg == '0) state_next = S_SWEEP;
      S_SWEEP: if (bus.i_start) state_next = S_SNAP;
               else if (idx_reg == c_end) state_next = (k_reg == dur_reg) ? S_IDLE : S_WAIT;
      default: state_next = S_CLEAR;
    endcase
  end

  // Status outputs; the final drain cycle of the last step reports completion.
  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    case (state_reg)
      S_IDLE:  busy = 1'b0;
      S_SWEEP: if (idx_reg == c_end && k_reg == dur_reg && !bus.i_start) begin
                 busy = 1'b0;
                 done = 1'b1;
               end
      default: ;
    endcase
  end

  // Channel index, step counter and the restoring divider for the blend factor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_reg <= '0;
      dur_reg <= '0;
      k_reg   <= '0;
      f_reg   <= '0;
      rem_reg <= '0;
      cnt_reg <= '0;
    end else begin
      if (state_next != state_reg || restart)
        idx_reg <= '0;
      else if (state_reg inside {S_CLEAR, S_SNAP, S_SWEEP})
        idx_reg <= idx_reg + 1'b1;

      if (restart) begin
        dur_reg <= bus.i_time;
        k_reg   <= '0;
      end else if (state_reg == S_SNAP && state_next == S_SWEEP) begin
        k_reg <= dur_reg;
        f_reg <= c_unity;
      end else if (state_reg == S_WAIT && state_next == S_DIV) begin
        k_reg   <= k_reg + 1'b1;
        rem_reg <= {1'b0, k_reg} + 1'b1;
        f_reg   <= '0;
        cnt_reg <= c_cnt_init;
      end else if (state_reg == S_DIV) begin
        // long division of k by dur, one quotient bit per cycle, MSB first
        f_reg   <= {f_reg[c_time_w-1:0], rem_ge};
        rem_reg <= rem_sub << 1;
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  // Step prescaler; a tick seen away from WAIT is remembered once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      pre_reg     <= tick ? '0 : pre_reg + 1'b1;
      pending_reg <= (state_reg == S_WAIT) ? 1'b0 : (pending_reg || tick);
    end
  end

  // Sweep blend: C = S + ((T - S) * f >>> c_time_w), clamped to the channel range.
  always_comb begin
    t_ext = {{(c_prod_w - c_bpc){1'b0}}, t_rd_reg};
    s_ext = {{(c_prod_w - c_bpc){1'b0}}, s_rd_reg};
    f_ext = {{(c_prod_w - c_time_w - 1){1'b0}}, f_reg};
    diff  = t_ext - s_ext;
    prod  = diff * f_ext;
    sum   = s_ext + (prod >>> c_time_w);
    if (sum[c_prod_w-1])   sweep_val = '0;
    else if (sum > c_max_p) sweep_val = '1;
    else                   sweep_val = sum[c_bpc-1:0];
  end

  // A C write landing while the snapshot reads the same channel is forwarded.
  assign snap_val = byp_hit_reg ? byp_data_reg : c_snap_reg;

  // Write-port arbitration; CLEAR owns every store, so host writes during it are dropped.
  always_comb begin
    t_we    = 1'b0;
    t_waddr = bus.i_addr;
    t_wdata = bus.i_data;
    s_we    = snap_valid_reg;
    s_waddr = snap_addr_reg;
    s_wdata = snap_val;
    c_we    = sw_valid_reg;
    c_waddr = sw_addr_reg;
    c_wdata = sweep_val;
    if (state_reg == S_CLEAR) begin
      t_we    = 1'b1;
      t_waddr = idx_addr;
      t_wdata = '0;
      s_we    = 1'b1;
      s_waddr = idx_addr;
      s_wdata = '0;
      c_we    = 1'b1;
      c_waddr = idx_addr;
      c_wdata = '0;
    end else if (bus.i_wen && wr_in_range) begin
      t_we = 1'b1;
    end
  end

  // Pipeline control between array reads and their dependent writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_valid_reg   <= 1'b0;
      snap_valid_reg <= 1'b0;
      byp_hit_reg    <= 1'b0;
      rd_oob_reg     <= 1'b0;
      sw_addr_reg    <= '0;
      snap_addr_reg  <= '0;
      byp_data_reg   <= '0;
    end else begin
      sw_valid_reg   <= (state_reg == S_SWEEP) && (idx_reg != c_end);
      snap_valid_reg <= (state_reg == S_SNAP);
      byp_hit_reg    <= c_we && (c_waddr == idx_addr);
      rd_oob_reg     <= !rd_in_range;
      sw_addr_reg    <= idx_addr;
      snap_addr_reg  <= idx_addr;
      byp_data_reg   <= c_wdata;
    end
  end

  // Target store.
  always_ff @(posedge i_clk) begin
    if (t_we) t_mem[t_waddr] <= t_wdata;
    t_rd_reg <= t_mem[idx_addr];
  end

  // Start (snapshot) store.
  always_ff @(posedge i_clk) begin
    if (s_we) s_mem[s_waddr] <= s_wdata;
    s_rd_reg <= s_mem[idx_addr];
  end

  // Current store with separate snapshot and driver read ports (read-before-write).
  always_ff @(posedge i_clk) begin
    if (c_we) c_mem[c_waddr] <= c_wdata;
    c_snap_reg <= c_mem[idx_addr];
    c_rd_reg   <= c_mem[bus.i_rd_addr];
  end

  assign bus.o_rd_data = rd_oob_reg ? '0 : c_rd_reg;
  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
endmodule

// File: tb/tb_keyframe_fader.sv
// Directed bench for keyframe_fader: 32-channel instance with a 64-clock step,
// plus a 96-channel instance used only for out-of-range addressing.
`timescale 1ns/1ps
module tb_keyframe_fader;
  localparam int c_ch    = 32;
  localparam int c_aw    = 5;
  localparam int c_bpc   = 12;
  localparam int c_tw    = 10;
  localparam int c_div   = 64;
  localparam int c_aw_b  = 7;
  localparam int c_div_b = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keyframe_fader_if #(.c_addr_w(c_aw),   .c_bpc(c_bpc), .c_time_w(c_tw)) bus ();
  keyframe_fader_if #(.c_addr_w(c_aw_b), .c_bpc(c_bpc), .c_time_w(c_tw)) bus_b ();

  keyframe_fader #(.c_ledboards(1), .c_tick_div(c_div)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave));

  keyframe_fader #(.c_ledboards(3), .c_tick_div(c_div_b)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cnt_b = 0;

  // completion pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.o_done === 1'b1)   done_cnt <= done_cnt + 1;
    if (bus_b.o_done === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.i_wen  = 1'b1;
    bus.i_addr = a[c_aw-1:0];
    bus.i_data = d[c_bpc-1:0];
    step();
    bus.i_wen  = 1'b0;
  endtask

  task automatic start(input int t);
    bus.i_start = 1'b1;
    bus.i_time  = t[c_tw-1:0];
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic rd(input int a, output int v);
    bus.i_rd_addr = a[c_aw-1:0];
    step();
    v = int'(bus.o_rd_data);
  endtask

  // poll one channel until it leaves 'old' (bounded); caller checks the new value
  task automatic wait_change(input int a, input int old, output int v);
    int n;
    n = 0;
    v = old;
    bus.i_rd_addr = a[c_aw-1:0];
    while (n < 400) begin
      step();
      v = int'(bus.o_rd_data);
      if (v != old) break;
      n++;
    end
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (done_cnt <= base && n < 600) begin
      step();
      n++;
    end
    check(tag, done_cnt - base, 1);
  endtask

  int v, n, base, prev, idx, bad;
  int lin_exp[4]  = '{'h200, 'h400, 'h600, 'h800};
  // -4095*341>>>10 = -1364, -4095*682>>>10 = -2728 (arithmetic shift floors)
  int down_exp[3] = '{'hAAB, 'h557, 'h000};
  logic [c_bpc-1:0] hist[$];

  initial begin
    bus.i_wen = 1'b0; bus.i_addr = '0; bus.i_data = '0; bus.i_time = '0;
    bus.i_start = 1'b0; bus.i_rd_addr = '0;
    bus_b.i_wen = 1'b0; bus_b.i_addr = '0; bus_b.i_data = '0; bus_b.i_time = '0;
    bus_b.i_start = 1'b0; bus_b.i_rd_addr = '0;

    assert (c_div > c_ch + c_tw + 8)
      else $fatal(1, "FAIL tick_budget div=%0d need>%0d", c_div, c_ch + c_tw + 8);

    // reset: one cycle, then CLEAR runs for one cycle per channel
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b1) break;
      n++;
    end
    check("clear_busy_cycles", n, c_ch);
    check("clear_done_quiet", done_cnt, 0);
    bad = 0;
    for (int i = 0; i < c_ch; i++) begin
      rd(i, v);
      if (v != 0) bad++;
      if (i < 2 || i == c_ch - 1) check($sformatf("reset_read_%0d", i), v, 0);
    end
    check("reset_nonzero_channels", bad, 0);
    check("idle_busy", bus.o_busy, 0);

    // instant fade: duration 0 lands on the target in a single sweep
    wr(5, 'hFFF);
    wr(1, 'hFFF);
    base = done_cnt;
    start(0);
    wait_done(base, "instant_done");
    repeat (5) step();
    check("instant_done_once", done_cnt - base, 1);
    rd(5, v); check("instant_c5", v, 'hFFF);
    rd(1, v); check("instant_c1", v, 'hFFF);
    rd(4, v); check("instant_c4", v, 0);
    check("instant_busy_after", bus.o_busy, 0);

    // linear upward fade over 4 steps
    wr(0, 'h800);
    base = done_cnt;
    start(4);
    prev = 0;
    for (int s = 0; s < 4; s++) begin
      wait_change(0, prev, v);
      check($sformatf("lin_step%0d", s + 1), v, lin_exp[s]);
      prev = v;
      if (s == 2) check("lin_no_early_done", done_cnt - base, 0);
    end
    wait_done(base, "lin_done");
    rd(1, v); check("lin_c1_held", v, 'hFFF);

    // downward fade to 0 with floor rounding, never below zero
    wr(1, 0);
    base = done_cnt;
    start(3);
    prev = 'hFFF;
    for (int s = 0; s < 3; s++) begin
      wait_change(1, prev, v);
      check($sformatf("down_step%0d", s + 1), v, down_exp[s]);
      prev = v;
    end
    wait_done(base, "down_done");
    rd(1, v); check("down_final", v, 0);
    rd(0, v); check("down_c0_held", v, 'h800);

    // restart mid-fade: new fade continues from wherever C stands
    wr(0, 0);
    base = done_cnt;
    start(0);
    wait_done(base, "restart_prep_done");
    rd(0, v); check("restart_c0_zero", v, 0);
    base = done_cnt;
    wr(0, 'h800);
    start(4);
    wait_change(0, 0, v);       check("restart_a1", v, 'h200);
    wait_change(0, 'h200, v);   check("restart_a2", v, 'h400);
    start(2);
    wait_change(0, 'h400, v);   check("restart_b1", v, 'h600);
    wait_change(0, 'h600, v);   check("restart_b2", v, 'h800);
    wait_done(base, "restart_done");
    repeat (300) step();
    check("restart_done_once", done_cnt - base, 1);

    // read/write collision on C[0]: C[0] is written c_ch-1 cycles before the
    // last channel (which coincides with o_done); a same-cycle read returns
    // the old value, so the new value shows c_ch-3 samples before o_done
    wr(0, 'h123);
    bus.i_rd_addr = '0;
    start(0);
    hist.delete();
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      hist.push_back(bus.o_rd_data);
      if (bus.o_done === 1'b1) break;
      n++;
    end
    idx = -1;
    for (int i = 0; i < hist.size(); i++)
      if (idx < 0 && hist[i] == 12'h123) idx = i;
    check("coll_change_seen", (idx > 0) ? 1 : 0, 1);
    check("coll_old_value", (idx > 0) ? int'(hist[idx-1]) : -1, 'h800);
    check("coll_new_lead", (idx > 0) ? (hist.size() - 1 - idx) : -1, c_ch - 3);
    step();

    // out-of-range target writes (96-channel instance)
    bus_b.i_wen = 1'b1; bus_b.i_addr = 7'd100; bus_b.i_data = 12'hFFF;
    step();
    bus_b.i_addr = 7'd127;
    step();
    bus_b.i_addr = 7'd40; bus_b.i_data = 12'hABC;
    step();
    bus_b.i_wen = 1'b0;
    base = done_cnt_b;
    bus_b.i_start = 1'b1; bus_b.i_time = '0;
    step();
    bus_b.i_start = 1'b0;
    n = 0;
    while (done_cnt_b <= base && n < 600) begin step(); n++; end
    check("oob_done", done_cnt_b - base, 1);
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      bus_b.i_rd_addr = 7'(i);
      step();
      if (i == 40) check("oob_c40_written", bus_b.o_rd_data, 'hABC);
      else if (bus_b.o_rd_data != '0) bad++;
    end
    check("oob_other_channels", bad, 0);
    bus_b.i_rd_addr = 7'd100;
    step();
    check("oob_read_100", bus_b.o_rd_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
